mem_port_arbiter: RTL and testbench

- Shares the read/write port B of the dual-port BRAM main memory between two requesters: requester 0 (CPU data/load-store) and requester 1 (DMA/debug loader).
- Each requester uses a valid/ready request channel and a 1-cycle-latency response channel.
- Supports a lock for atomic read-modify-write sequences.
- Sits between the core/DMA and the memory's port B. Port A (instruction fetch) is untouched.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/arb_grant.sv | 27 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port-B arbiter
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        lock;
    } mem_req_t;

    function automatic arb_state_t locked_state(input logic idx);
        return idx ? LOCKED1 : LOCKED0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester channels and memory port-B signal bundle
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int MEM_SIZE = 8192
);
    localparam int ADDR_W = $clog2(MEM_SIZE);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][31:0]       req_wdata;
    logic [NUM_REQ-1:0][3:0]        req_be;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [31:0]                    rsp_rdata;
    logic [ADDR_W-1:0]              mem_addr;
    logic [31:0]                    mem_wdata;
    logic [3:0]                     mem_be;
    logic                           mem_we;
    logic [31:0]                    mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_be, req_we, req_lock, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_be, mem_we
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_be, req_we, req_lock, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_be, mem_we
    );

endinterface

// File: rtl/arb_grant.sv
// rtl/arb_grant.sv - combinational one-hot winner select for two requesters
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    input  arb_state_t         state,
    output logic [NUM_REQ-1:0] grant
);

    // ptr names the preferred requester; tie it low for fixed priority
    always_comb begin
        grant = '0;
        case (state)
            LOCKED0: grant[0] = valid[0];
            LOCKED1: grant[1] = valid[1];
            default: begin
                if (valid[ptr]) begin
                    grant[ptr] = 1'b1;
                end else if (valid[~ptr]) begin
                    grant[~ptr] = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for memory port B with RMW lock
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration in FREE; default is fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_SIZE = 8192
)
(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int ADDR_W = $clog2(MEM_SIZE);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic               ptr;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic               win;
    mem_req_t           req [NUM_REQ];
    mem_req_t           sel;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [NUM_REQ-1:0] rsp_q;
    logic               unused_addr_hi;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].addr  = 32'(bus.req_addr[i]);
            req[i].wdata = bus.req_wdata[i];
            req[i].be    = bus.req_be[i];
            req[i].we    = bus.req_we[i];
            req[i].lock  = bus.req_lock[i];
        end
    end

    arb_grant u_grant (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .state (state_q),
        .grant (grant)
    );

    assign bus.req_ready  = rst ? '0 : grant;
    assign xfer           = |bus.req_ready;
    assign win            = bus.req_ready[1];
    assign sel            = req[win];
    assign unused_addr_hi = ^sel.addr[31:ADDR_W];

    // Idle cycles park the address/data bus on the last winner to avoid toggling
    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_be    = '0;
        bus.mem_we    = 1'b0;
        if (rst) begin
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end else if (xfer) begin
            bus.mem_addr  = sel.addr[ADDR_W-1:0];
            bus.mem_wdata = sel.wdata;
            bus.mem_be    = sel.be;
            bus.mem_we    = sel.we;
        end
    end

    // In LOCKEDi only i can win, so the winner's lock bit alone decides the next state
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = sel.lock ? locked_state(win) : FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            rsp_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= bus.req_ready;
            if (xfer) begin
                addr_q  <= sel.addr[ADDR_W-1:0];
                wdata_q <= sel.wdata;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    // Pointer stays frozen across a locked sequence and moves on its releasing transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (xfer && !sel.lock) begin
            ptr_q <= ~win;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    // A reset landing on the response cycle kills the response outright
    assign bus.rsp_valid = rst ? '0 : rsp_q;
    assign bus.rsp_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a reference model
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MEM_SIZE = 8192;
    localparam int ADDR_W   = $clog2(MEM_SIZE);
    localparam int WORDS    = MEM_SIZE / 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.MEM_SIZE(MEM_SIZE)) bus ();
    mem_port_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'hDEADBEEF : 32'(k) * 32'h9E3779B9;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Block RAM behind port B: registered read-first, byte-enabled writes
    logic [31:0] env_mem [WORDS];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WORDS; k++) env_mem[k] <= init_word(k);
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) env_mem[bus.mem_addr[ADDR_W-1:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        bus.mem_rdata <= env_mem[bus.mem_addr[ADDR_W-1:2]];
    end

    // Reference model: lock owner, preferred requester, pending response and a golden memory
    int                lock_owner = -1;
    int                ptr_m      = 0;
    logic [1:0]        pend       = 2'b00;
    logic              pend_rd    = 1'b0;
    logic [31:0]       pend_data  = '0;
    logic [ADDR_W-1:0] last_addr  = '0;
    logic [31:0]       last_wdata = '0;
    logic [31:0]       gold [WORDS];

    always @(negedge clk) begin : model
        logic [1:0]        er;
        int                w, pref, idx;
        logic [ADDR_W-1:0] eaddr;
        logic [31:0]       ewd;
        er = 2'b00;
        if (!rst) begin
            if (lock_owner >= 0) begin
                er[lock_owner] = bus.req_valid[lock_owner];
            end else begin
                pref = RR_EN ? ptr_m : 0;
                if (bus.req_valid[pref]) er[pref] = 1'b1;
                else if (bus.req_valid[1-pref]) er[1-pref] = 1'b1;
            end
        end
        w     = er[1] ? 1 : 0;
        eaddr = rst ? '0 : (er != 2'b00) ? bus.req_addr[w] : last_addr;
        ewd   = rst ? '0 : (er != 2'b00) ? bus.req_wdata[w] : last_wdata;
        check("req_ready", 32'(bus.req_ready), 32'(er));
        check("rsp_valid", 32'(bus.rsp_valid), rst ? 32'd0 : 32'(pend));
        if (!rst && pend != 2'b00 && pend_rd) check("rsp_rdata", bus.rsp_rdata, pend_data);
        check("mem_we", 32'(bus.mem_we), 32'((er != 2'b00) && bus.req_we[w]));
        check("mem_be", 32'(bus.mem_be), (er != 2'b00) ? 32'(bus.req_be[w]) : 32'd0);
        check("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
        check("mem_wdata", bus.mem_wdata, ewd);
        if (rst) begin
            lock_owner = -1; ptr_m = 0; pend = 2'b00; pend_rd = 1'b0;
            last_addr = '0; last_wdata = '0;
            for (int k = 0; k < WORDS; k++) gold[k] = init_word(k);
        end else begin
            pend = er;
            if (er != 2'b00) begin
                idx       = int'(bus.req_addr[w][ADDR_W-1:2]);
                pend_rd   = !bus.req_we[w];
                pend_data = gold[idx];
                if (bus.req_we[w])
                    for (int b = 0; b < 4; b++)
                        if (bus.req_be[w][b]) gold[idx][8*b +: 8] = bus.req_wdata[w][8*b +: 8];
                last_addr  = bus.req_addr[w];
                last_wdata = bus.req_wdata[w];
                if (bus.req_lock[w]) lock_owner = w;
                else begin lock_owner = -1; ptr_m = 1 - w; end
            end
        end
    end

    task automatic set_req(input int i, input bit v, input int a, input bit we,
                           input logic [31:0] wd, input logic [3:0] be, input bit lk);
        bus.req_valid[i] = v;
        bus.req_addr[i]  = ADDR_W'(a);
        bus.req_we[i]    = we;
        bus.req_wdata[i] = wd;
        bus.req_be[i]    = be;
        bus.req_lock[i]  = lk;
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, '0, 4'h0, 0);
        set_req(1, 0, 0, 0, '0, 4'h0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.req_valid = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        check("reset ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_be", 32'(bus.mem_be), 32'd0);
        check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        step();
        step();
        rst = 1'b0;
        idle();

        // single read by requester 1
        step();
        set_req(1, 1, 'h10, 0, '0, 4'hF, 0);
        @(negedge clk);
        check("single rd ready", 32'(bus.req_ready), 32'd2);
        step();
        idle();
        @(negedge clk);
        check("single rd rsp_valid", 32'(bus.rsp_valid), 32'd2);
        check("single rd rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // both requesting for four cycles
        step();
        set_req(0, 1, 'h100, 0, '0, 4'hF, 0);
        set_req(1, 1, 'h104, 0, '0, 4'hF, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("conflict ready", 32'(bus.req_ready), (RR_EN && (k % 2 == 1)) ? 32'd2 : 32'd1);
            step();
        end
        set_req(0, 0, 0, 0, '0, 4'h0, 0);
        @(negedge clk);
        check("conflict drop ready", 32'(bus.req_ready), 32'd2);

        // locked read-modify-write by requester 0
        step();
        set_req(0, 1, 'h20, 0, '0, 4'hF, 1);
        set_req(1, 1, 'h20, 0, '0, 4'hF, 0);
        @(negedge clk);
        check("lock acquire ready", 32'(bus.req_ready), 32'd1);
        step();
        set_req(0, 0, 0, 0, '0, 4'h0, 0);
        @(negedge clk);
        check("lock idle ready", 32'(bus.req_ready), 32'd0);
        step();
        set_req(0, 1, 'h20, 1, 32'h000000AA, 4'b0001, 0);
        @(negedge clk);
        check("lock release ready", 32'(bus.req_ready), 32'd1);
        step();
        set_req(0, 0, 0, 0, '0, 4'h0, 0);
        @(negedge clk);
        check("after release ready", 32'(bus.req_ready), 32'd2);
        step();
        idle();
        @(negedge clk);
        check("rmw rsp_valid", 32'(bus.rsp_valid), 32'd2);
        check("rmw low byte", 32'(bus.rsp_rdata[7:0]), 32'hAA);

        // back-to-back write then read
        step();
        set_req(0, 1, 'h40, 1, 32'h12345678, 4'hF, 0);
        @(negedge clk);
        check("b2b wr mem_we", 32'(bus.mem_we), 32'd1);
        step();
        set_req(0, 1, 'h40, 0, '0, 4'hF, 0);
        @(negedge clk);
        check("b2b wr rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b rd ready", 32'(bus.req_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("b2b rd rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b rd rdata", bus.rsp_rdata, 32'h12345678);

        // reset on the response cycle of a locked read
        step();
        set_req(0, 1, 'h10, 0, '0, 4'hF, 1);
        @(negedge clk);
        check("pre-reset ready", 32'(bus.req_ready), 32'd1);
        step();
        idle();
        set_req(1, 1, 'h10, 0, '0, 4'hF, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid reset mem_we", 32'(bus.mem_we), 32'd0);
        check("mid reset ready", 32'(bus.req_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post reset ready", 32'(bus.req_ready), 32'd2);
        step();
        idle();
        @(negedge clk);
        check("post reset rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // randomized traffic on a small address window to force read-after-write hits
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++)
                set_req(i, $urandom_range(0, 9) < 7, int'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                        $urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3) == 0);
        end
        step();
        rst = 1'b0;
        idle();
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
